ntt_intt_sched: RTL and testbench
=================================

Name: ntt_intt_sched

Overview:
- Sequencer for the memory-mapped NTT/INTT accelerator slave (Kyber, N=256).
- Issues butterfly read addresses, zeta indices and op codes to the butterfly datapath, then write-back addresses after the pipeline latency.
- Inserts pipeline drains between layers. For INTT, appends the final scaling pass.
- Started and monitored by the register interface on the peripheral port.

Parameters:
- BF_LATENCY, 3, butterfly pipeline depth in enabled cycles (1..8)
- ADDR_W, 8, coefficient address width (log2 256)
- ZIDX_W, 7, zeta table index width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- start_i  in  1  start request; accepted only in IDLE
- mode_i  in  1  0=NTT, 1=INTT; sampled with an accepted start
- stall_i  in  1  freezes all sequencing (memory/bus conflict)
- busy_o  out  1  high from accepted start through DONE
- done_o  out  1  one-cycle completion pulse
- bf_en_o  out  1  butterfly pipeline advance = busy_o & ~stall_i
- bf_valid_o  out  1  issue valid this cycle
- addr_a_o, addr_b_o  out  ADDR_W  read addresses
- zeta_idx_o  out  ZIDX_W  twiddle index
- op_o  out  2  0=CT, 1=GS, 2=SCALE
- wb_valid_o  out  1  write-back valid
- wb_addr_a_o, wb_addr_b_o  out  ADDR_W  write-back addresses

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset, including mid-operation: state IDLE, all counters and the delay line cleared, every output 0. No done_o is produced for an aborted operation.
- States: IDLE, BFLY, DRAIN, SCALE, SDRAIN, DONE.
- IDLE:
  - start_i=1 latches mode_i and clears layer (3b), bf_cnt (7b) and drain counter.
  - zeta counter is set to 1 for NTT, 127 for INTT.
  - Next state BFLY.
- BFLY: one butterfly per enabled cycle, bf_valid_o=1.
  - lg = 7-layer for NTT, 1+layer for INTT; len = 1<<lg.
  - group = bf_cnt>>lg.
  - addr_a = (group<<(lg+1)) | (bf_cnt & (len-1)).
  - addr_b = addr_a + len.
  - op_o = mode.
  - zeta_idx_o = zeta counter. At the last butterfly of each group it steps: +1 for NTT, -1 for INTT.
  - At bf_cnt=127: go to DRAIN, bf_cnt wraps to 0.
- DRAIN: no issue; counts BF_LATENCY enabled cycles so the layer's write-backs land before the next layer reads.
  - If layer<6: layer+1, back to BFLY.
  - Else: NTT goes to DONE, INTT goes to SCALE.
- SCALE: 128 issues, addr_a=2i, addr_b=2i+1, op_o=2, zeta_idx_o=0. Then SDRAIN (BF_LATENCY cycles), then DONE.
- DONE: done_o=1 for one cycle, busy_o=0 in this cycle, then IDLE.
- Write-back: a BF_LATENCY-deep delay line of {valid, addr_a, addr_b}.
  - It shifts only when bf_en_o=1.
  - wb_valid_o = tail.valid & ~stall_i.
- Stall: stall_i=1 freezes state, counters, drain counter and delay line, and forces bf_valid_o=0 and wb_valid_o=0. Address outputs hold their values.
- start_i while busy is ignored. start_i and done in the same cycle: start is ignored (DONE is not IDLE).
- Timing (L=BF_LATENCY, no stalls, start accepted at cycle 0):
  - first issue at cycle 1.
  - NTT done_o at cycle 1+7*(128+L).
  - INTT done_o at cycle 1+8*(128+L).
  - Each stall cycle adds exactly one cycle.

Optional Feature:
- Macro NTT_INTT_SCHED_PERF_EN.
- When defined: adds output perf_cycles_o (16b).
  - Cleared on an accepted start.
  - Increments every busy cycle, stalled cycles included.
  - Holds its value after done until the next start. Reset value 0.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package ntt_intt_sched_pkg: state enum, op-code enum (OP_CT, OP_GS, OP_SCALE), N=256, NUM_LAYERS=7, BF_PER_LAYER=128, NTT_ZETA_INIT=1, INTT_ZETA_INIT=127.
- One sub-module, ntt_intt_wb_delay: a parameterized shift register with enable, carrying {valid, addr_a, addr_b}.

Test Plan:
- NTT, L=3, no stall:
  - cycle 1 issues a=0, b=128, zeta=1, op=0.
  - layer 1 first issue is a=0, b=64, zeta=2.
  - layer 6 last issue is a=253, b=255, zeta=127.
  - done_o pulses at cycle 918; exactly 896 bf_valid and 896 wb_valid pulses.
- INTT, L=3:
  - first issue a=0, b=2, zeta=127, op=1.
  - layer 6 last issue is a=127, b=255, zeta=1.
  - scale issues a=0/b=1 through a=254/b=255 with op=2.
  - done_o at cycle 1049.
- Write-back check: every wb address pair equals the issue pair from exactly L enabled cycles earlier.
  - No wb_valid occurs while the next layer is issuing a conflicting address.
- Stall: stall_i held for 5 cycles mid-layer 3, plus 2 cycles during DRAIN.
  - bf_valid_o and wb_valid_o are 0 while stalled; issue resumes with the same address.
  - done_o arrives 7 cycles late (cycle 925 for NTT).
- Reset and start handling:
  - rst_i at cycle 400 returns the block to IDLE with all outputs 0.
  - start_i at cycle 200 during a busy NTT is ignored (done still at cycle 918).
  - A new start after reset runs cleanly.
- With NTT_INTT_SCHED_PERF_EN: NTT with 7 stall cycles gives perf_cycles_o = 925, held after done; cleared by the next start.

Source files
------------

// File: rtl/ntt_intt_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntt_intt_sched_pkg                                                   |
// | Shared types and constants for the Kyber NTT/INTT sequencer.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ntt_intt_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BFLY   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SCALE  = 3'd3,
    ST_SDRAIN = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_CT    = 2'd0,
    OP_GS    = 2'd1,
    OP_SCALE = 2'd2
  } op_e;

  localparam int N            = 256;
  localparam int NUM_LAYERS   = 7;
  localparam int BF_PER_LAYER = 128;

  localparam logic [6:0] NTT_ZETA_INIT  = 7'd1;
  localparam logic [6:0] INTT_ZETA_INIT = 7'd127;

  // Upper read address of butterfly bf_cnt when the half-span is 1<<lg.
  function automatic logic [7:0] bfly_addr_a(input logic [6:0] bf_cnt,
                                             input logic [2:0] lg);
    logic [7:0] cnt8;
    logic [7:0] mask;
    logic [3:0] sh;
    cnt8 = {1'b0, bf_cnt};
    mask = (8'd1 << lg) - 8'd1;
    sh   = {1'b0, lg} + 4'd1;
    return ((cnt8 >> lg) << sh) | (cnt8 & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_intt_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntt_intt_sched_if                                                    |
// | Control, issue and write-back bus between sequencer and datapath.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ntt_intt_sched_if
  import ntt_intt_sched_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ZIDX_W = 7
);
  logic              start_i;
  logic              mode_i;
  logic              stall_i;
  logic              busy_o;
  logic              done_o;
  logic              bf_en_o;
  logic              bf_valid_o;
  logic [ADDR_W-1:0] addr_a_o;
  logic [ADDR_W-1:0] addr_b_o;
  logic [ZIDX_W-1:0] zeta_idx_o;
  op_e               op_o;
  logic              wb_valid_o;
  logic [ADDR_W-1:0] wb_addr_a_o;
  logic [ADDR_W-1:0] wb_addr_b_o;

  // The sequencer is the master of the issue/write-back streams.
  modport master (
    input  start_i, mode_i, stall_i,
    output busy_o, done_o, bf_en_o, bf_valid_o, addr_a_o, addr_b_o,
           zeta_idx_o, op_o, wb_valid_o, wb_addr_a_o, wb_addr_b_o
  );

  modport slave (
    output start_i, mode_i, stall_i,
    input  busy_o, done_o, bf_en_o, bf_valid_o, addr_a_o, addr_b_o,
           zeta_idx_o, op_o, wb_valid_o, wb_addr_a_o, wb_addr_b_o
  );

endinterface
`default_nettype wire

// File: rtl/ntt_intt_sched_wb_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntt_intt_wb_delay                                                    |
// | Enabled shift register aligning write-back with the butterfly pipe.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ntt_intt_wb_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ntt_intt_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntt_intt_sched                                                       |
// | Kyber NTT/INTT butterfly sequencer with write-back alignment.        |
// | Optional perf counter: define NTT_INTT_SCHED_PERF_EN.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ntt_intt_sched
  import ntt_intt_sched_pkg::*;
#(
  parameter int BF_LATENCY = 3,
  parameter int ADDR_W     = 8,
  parameter int ZIDX_W     = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  ntt_intt_sched_if.master bus
`ifdef NTT_INTT_SCHED_PERF_EN
  ,
  output logic [15:0] perf_cycles_o
`endif
);

  localparam int DRAIN_W = 4;
  localparam int WB_W    = 1 + 2 * ADDR_W;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [2:0]           layer_q, layer_d;
  logic [6:0]           bf_cnt_q, bf_cnt_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [6:0]           zeta_q, zeta_d;

  logic                 busy;
  logic                 adv;
  logic                 issue;
  logic                 grp_last;
  logic                 drain_last;
  logic [2:0]           lg;
  logic [7:0]           len;
  logic [6:0]           grp_mask;
  logic [7:0]           addr_a;
  logic [7:0]           addr_b;
  logic [6:0]           zeta_out;
  op_e                  op_out;
  logic [WB_W-1:0]      wb_in;
  logic [WB_W-1:0]      wb_out;

  assign busy = (state_q == ST_BFLY)  || (state_q == ST_DRAIN) ||
                (state_q == ST_SCALE) || (state_q == ST_SDRAIN);
  assign adv  = busy & ~bus.stall_i;

  // NTT walks spans 128..2, INTT walks 2..128.
  assign lg         = mode_q ? (layer_q + 3'd1) : (3'd7 - layer_q);
  assign len        = 8'd1 << lg;
  assign grp_mask   = 7'(len - 8'd1);
  assign grp_last   = (bf_cnt_q & grp_mask) == grp_mask;
  assign drain_last = drain_q == DRAIN_W'(BF_LATENCY - 1);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    layer_d  = layer_q;
    bf_cnt_d = bf_cnt_q;
    drain_d  = drain_q;
    zeta_d   = zeta_q;
    issue    = 1'b0;
    addr_a   = '0;
    addr_b   = '0;
    zeta_out = '0;
    op_out   = OP_CT;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          mode_d   = bus.mode_i;
          layer_d  = '0;
          bf_cnt_d = '0;
          drain_d  = '0;
          zeta_d   = bus.mode_i ? INTT_ZETA_INIT : NTT_ZETA_INIT;
          state_d  = ST_BFLY;
        end
      end

      ST_BFLY: begin
        issue    = 1'b1;
        addr_a   = bfly_addr_a(bf_cnt_q, lg);
        addr_b   = addr_a + len;
        zeta_out = zeta_q;
        op_out   = mode_q ? OP_GS : OP_CT;
        if (adv) begin
          bf_cnt_d = bf_cnt_q + 7'd1;
          if (grp_last) begin
            zeta_d = mode_q ? (zeta_q - 7'd1) : (zeta_q + 7'd1);
          end
          if (bf_cnt_q == 7'(BF_PER_LAYER - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (adv) begin
          if (drain_last) begin
            drain_d = '0;
            if (layer_q < 3'(NUM_LAYERS - 1)) begin
              layer_d = layer_q + 3'd1;
              state_d = ST_BFLY;
            end else begin
              state_d = mode_q ? ST_SCALE : ST_DONE;
            end
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
      end

      ST_SCALE: begin
        issue  = 1'b1;
        addr_a = {bf_cnt_q, 1'b0};
        addr_b = {bf_cnt_q, 1'b1};
        op_out = OP_SCALE;
        if (adv) begin
          bf_cnt_d = bf_cnt_q + 7'd1;
          if (bf_cnt_q == 7'(BF_PER_LAYER - 1)) begin
            state_d = ST_SDRAIN;
          end
        end
      end

      ST_SDRAIN: begin
        if (adv) begin
          if (drain_last) begin
            drain_d = '0;
            state_d = ST_DONE;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      layer_q  <= '0;
      bf_cnt_q <= '0;
      drain_q  <= '0;
      zeta_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      layer_q  <= layer_d;
      bf_cnt_q <= bf_cnt_d;
      drain_q  <= drain_d;
      zeta_q   <= zeta_d;
    end
  end

  assign wb_in = {issue, ADDR_W'(addr_a), ADDR_W'(addr_b)};

  ntt_intt_wb_delay #(
    .DEPTH (BF_LATENCY),
    .WIDTH (WB_W)
  ) u_wb_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (adv),
    .d_i   (wb_in),
    .q_o   (wb_out)
  );

  assign bus.busy_o      = busy;
  assign bus.done_o      = state_q == ST_DONE;
  assign bus.bf_en_o     = adv;
  assign bus.bf_valid_o  = issue & ~bus.stall_i;
  assign bus.addr_a_o    = ADDR_W'(addr_a);
  assign bus.addr_b_o    = ADDR_W'(addr_b);
  assign bus.zeta_idx_o  = ZIDX_W'(zeta_out);
  assign bus.op_o        = op_out;
  assign bus.wb_valid_o  = wb_out[WB_W-1] & ~bus.stall_i;
  assign bus.wb_addr_a_o = wb_out[2*ADDR_W-1:ADDR_W];
  assign bus.wb_addr_b_o = wb_out[ADDR_W-1:0];

`ifdef NTT_INTT_SCHED_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Counts from the first busy cycle up to and including the DONE cycle.
  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_IDLE) begin
      if (bus.start_i) begin
        perf_d = '0;
      end
    end else begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_intt_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ntt_intt_sched                                                    |
// | Scoreboard bench for ntt_intt_sched (NTT_INTT_SCHED_PERF_EN aware).  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ntt_intt_sched;
  import ntt_intt_sched_pkg::*;

  localparam int L = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_intt_sched_if #(.ADDR_W(8), .ZIDX_W(7)) bus ();
`ifdef NTT_INTT_SCHED_PERF_EN
  logic [15:0] perf;
`endif

  ntt_intt_sched #(
    .BF_LATENCY (L),
    .ADDR_W     (8),
    .ZIDX_W     (7)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef NTT_INTT_SCHED_PERF_EN
    ,
    .perf_cycles_o (perf)
`endif
  );

  typedef struct {
    int          rel;
    logic [24:0] val;
  } spot_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  int done_cnt = 0;
  int n_iss = 0;
  int n_wb = 0;
  int en_idx = 0;

  logic [24:0] exp_iss[$];
  logic [15:0] exp_wb[$];
  int          exp_done[$];
  int          iss_en[$];
  spot_t       spots[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc - base);
  endtask

  function automatic logic [24:0] pk(input int a, input int b, input int z, input int op);
    return {a[7:0], b[7:0], z[6:0], op[1:0]};
  endfunction

  // Reference ordering taken from the textbook Kyber loops.
  task automatic push_model(input bit mode);
    int k;
    if (!mode) begin
      k = 1;
      for (int len = 128; len >= 2; len = len / 2) begin
        for (int st = 0; st < 256; st += 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            exp_iss.push_back(pk(j, j + len, k, 0));
            exp_wb.push_back({8'(j), 8'(j + len)});
          end
          k++;
        end
      end
    end else begin
      k = 127;
      for (int len = 2; len <= 128; len = len * 2) begin
        for (int st = 0; st < 256; st += 2 * len) begin
          for (int j = st; j < st + len; j++) begin
            exp_iss.push_back(pk(j, j + len, k, 1));
            exp_wb.push_back({8'(j), 8'(j + len)});
          end
          k--;
        end
      end
      for (int i = 0; i < 128; i++) begin
        exp_iss.push_back(pk(2 * i, 2 * i + 1, 0, 2));
        exp_wb.push_back({8'(2 * i), 8'(2 * i + 1)});
      end
    end
  endtask

  task automatic push_spots(input bit mode);
    if (!mode) begin
      spots.push_back('{1,   pk(0, 128, 1, 0)});
      spots.push_back('{132, pk(0, 64, 2, 0)});
      spots.push_back('{914, pk(253, 255, 127, 0)});
    end else begin
      spots.push_back('{1,    pk(0, 2, 127, 1)});
      spots.push_back('{914,  pk(127, 255, 1, 1)});
      spots.push_back('{918,  pk(0, 1, 0, 2)});
      spots.push_back('{1045, pk(254, 255, 0, 2)});
    end
  endtask

  always @(negedge clk) begin : p_mon
    int          rel;
    int          lat;
    logic [24:0] cur;
    rel = cyc - base;
    cur = {bus.addr_a_o, bus.addr_b_o, bus.zeta_idx_o, bus.op_o};
    if (bus.stall_i && !rst)
      chk("stall_quiet", 32'({bus.bf_valid_o, bus.wb_valid_o}), 32'(0));
    if (spots.size() > 0 && spots[0].rel == rel) begin
      chk("spot_issue", 32'({bus.bf_valid_o, cur}), 32'({1'b1, spots[0].val}));
      void'(spots.pop_front());
    end
    if (bus.bf_valid_o) begin
      n_iss++;
      if (exp_iss.size() == 0) fail_event("issue_unexpected");
      else chk("issue", 32'(cur), 32'(exp_iss.pop_front()));
      iss_en.push_back(en_idx);
    end
    if (bus.wb_valid_o) begin
      n_wb++;
      if (exp_wb.size() == 0 || iss_en.size() == 0) fail_event("wb_unexpected");
      else begin
        lat = en_idx - iss_en.pop_front();
        chk("wb_addr_lat", {bus.wb_addr_a_o, bus.wb_addr_b_o, 16'(lat)},
            {exp_wb.pop_front(), 16'(L)});
      end
    end
    if (bus.bf_valid_o && bus.wb_valid_o)
      chk("wb_conflict", 32'((bus.wb_addr_a_o == bus.addr_a_o) || (bus.wb_addr_a_o == bus.addr_b_o) ||
                             (bus.wb_addr_b_o == bus.addr_a_o) || (bus.wb_addr_b_o == bus.addr_b_o)), 32'(0));
    if (bus.done_o) begin
      done_cnt++;
      if (exp_done.size() == 0) fail_event("done_unexpected");
      else chk("done_cycle", rel, exp_done.pop_front());
      chk("busy_at_done", 32'(bus.busy_o), 32'(0));
    end
    if (bus.bf_en_o) en_idx++;
  end

  task automatic idle_zero();
    chk("idle_ctrl", 32'({bus.busy_o, bus.done_o, bus.bf_en_o, bus.bf_valid_o, bus.wb_valid_o}), 32'(0));
    chk("idle_addr", 32'({bus.addr_a_o, bus.addr_b_o}), 32'(0));
    chk("idle_zeta_op", 32'({bus.zeta_idx_o, bus.op_o}), 32'(0));
    chk("idle_wb_addr", 32'({bus.wb_addr_a_o, bus.wb_addr_b_o}), 32'(0));
`ifdef NTT_INTT_SCHED_PERF_EN
    chk("idle_perf", 32'(perf), 32'(0));
`endif
  endtask

  task automatic run_op(input bit mode, input int exp_done_cyc, input bit do_stall,
                        input bit busy_start, input bit do_rst);
    int d0;
    int n_exp;
    bit fin;
    if (!do_rst) exp_done.push_back(exp_done_cyc);
    push_model(mode);
    if (!do_stall) push_spots(mode);
    n_exp = mode ? 1024 : 896;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.mode_i  = mode;
    base  = cyc;
    n_iss = 0;
    n_wb  = 0;
    d0    = done_cnt;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
`ifdef NTT_INTT_SCHED_PERF_EN
    chk("perf_clear", 32'(perf), 32'(0));
`endif
    fin = 1'b0;
    for (int g = 0; g < exp_done_cyc + 40 && !fin; g++) begin
      int rel;
      rel = cyc - base;
      bus.stall_i = do_stall && ((rel >= 444 && rel <= 448) || rel == 658 || rel == 659);
      bus.start_i = busy_start && (rel == 200);
      rst = do_rst && (rel == 400);
      if (do_rst && rel == 401) begin
        exp_iss.delete();
        exp_wb.delete();
        iss_en.delete();
        spots.delete();
        fin = 1'b1;
      end else if (done_cnt != d0) begin
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    bus.stall_i = 1'b0;
    bus.start_i = 1'b0;
    if (do_rst) begin
      @(negedge clk);
      idle_zero();
      repeat (20) @(negedge clk);
      chk("no_done_after_abort", done_cnt - d0, 0);
    end else begin
      chk("done_seen", done_cnt - d0, 1);
      chk("issue_count", n_iss, n_exp);
      chk("wb_count", n_wb, n_exp);
      chk("queues_empty", exp_iss.size() + exp_wb.size() + exp_done.size() + spots.size(), 0);
      repeat (3) @(negedge clk);
`ifdef NTT_INTT_SCHED_PERF_EN
      chk("perf_held", 32'(perf), 32'(exp_done_cyc));
`endif
    end
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.stall_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle_zero();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op(1'b0, 918, 1'b0, 1'b1, 1'b0);   // NTT, stray start at cycle 200
    run_op(1'b1, 1049, 1'b0, 1'b0, 1'b0);  // INTT with scaling pass
    run_op(1'b0, 925, 1'b1, 1'b0, 1'b0);   // NTT with 5+2 stall cycles
    run_op(1'b0, 918, 1'b0, 1'b0, 1'b1);   // NTT aborted by reset at 400
    run_op(1'b0, 918, 1'b0, 1'b0, 1'b0);   // clean restart

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
